hack_memory_map: RTL and testbench

//  Parametrised data-memory map for the Hack CPU: decodes the CPU address into RAM, screen
//  and keyboard regions. Holds the RAM array; the screen framebuffer sits outside, behind a port.

---
 rtl/hack_memory_map.sv | 172 +++++++++++++++++
 tb/tb_hack_memory_map.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_memory_map.sv
// Hack CPU data-memory map: RAM array, screen port and keyboard register behind one address
// space, with a two-stage pipelined read path and an out-of-map error pulse.
module hack_memory_map #(
   parameter int unsigned       DATA_W      = 16,
   parameter int unsigned       ADDR_W      = 15,
   parameter int unsigned       RAM_AW      = 14,
   parameter int unsigned       SCREEN_AW   = 13,
   parameter logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000,
   parameter logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000,
   parameter int unsigned       KBD_STICKY  = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_W-1:0]    in,
   input  logic                 load,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    address,
   output logic [DATA_W-1:0]    out,
   output logic                 out_valid,
   output logic                 err,
   input  logic [DATA_W-1:0]    kb,
   input  logic                 kb_strobe,
   output logic [SCREEN_AW-1:0] scr_addr,
   output logic                 scr_we,
   output logic [DATA_W-1:0]    scr_wdata,
   input  logic [DATA_W-1:0]    scr_rdata
);

   localparam logic [1:0] SEL_RAM = 2'd0;
   localparam logic [1:0] SEL_SCR = 2'd1;
   localparam logic [1:0] SEL_KBD = 2'd2;
   localparam logic [1:0] SEL_BAD = 2'd3;

   // ---------------------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------------------
   logic              hit_ram;
   logic              hit_scr;
   logic              hit_kbd;
   logic              hit_bad;
   logic [1:0]        region;
   logic [RAM_AW-1:0] ram_idx;
   logic              rd_acc;
   logic              wr_err;
   logic              kbd_clr;

   assign hit_ram = (address < SCREEN_BASE);
   assign hit_scr = (address >= SCREEN_BASE) && (address < KBD_ADDR);
   assign hit_kbd = (address == KBD_ADDR);
   assign hit_bad = (address > KBD_ADDR);
   assign ram_idx = address[RAM_AW-1:0];

   always_comb begin
      region = SEL_BAD;
      if (hit_ram) begin
         region = SEL_RAM;
      end else if (hit_scr) begin
         region = SEL_SCR;
      end else if (hit_kbd) begin
         region = SEL_KBD;
      end
   end

   // A simultaneous write wins over a read; the read is silently dropped.
   assign rd_acc  = rd_en & ~load;
   assign wr_err  = load & (hit_kbd | hit_bad);
   assign kbd_clr = rd_acc & hit_kbd;

   // ---------------------------------------------------------------------------------------
   // Screen port (combinational pass-through to the external framebuffer)
   // ---------------------------------------------------------------------------------------
   assign scr_addr  = address[SCREEN_AW-1:0] - SCREEN_BASE[SCREEN_AW-1:0];
   assign scr_we    = load & hit_scr;
   assign scr_wdata = in;

   // ---------------------------------------------------------------------------------------
   // RAM array with registered read; left unreset so it maps onto block RAM
   // ---------------------------------------------------------------------------------------
   logic [DATA_W-1:0] ram [2**RAM_AW];
   logic [DATA_W-1:0] ram_q;

   always_ff @(posedge clk) begin
      if (load && hit_ram) begin
         ram[ram_idx] <= in;
      end
      if (rd_acc) begin
         ram_q <= ram[ram_idx];
      end
   end

   // ---------------------------------------------------------------------------------------
   // Keyboard register
   // ---------------------------------------------------------------------------------------
   logic [DATA_W-1:0] kbd_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kbd_q <= '0;
      end else if (KBD_STICKY != 0) begin
         // A new strobe beats the clear-on-read so a fresh key is never lost.
         if (kb_strobe) begin
            kbd_q <= kb;
         end else if (kbd_clr) begin
            kbd_q <= '0;
         end
      end else begin
         kbd_q <= kb;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Read stage 1: region select and keyboard sample travel with the RAM read
   // ---------------------------------------------------------------------------------------
   logic              s1_valid;
   logic [1:0]        s1_sel;
   logic [DATA_W-1:0] s1_kbd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_sel   <= SEL_RAM;
         s1_kbd   <= '0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) begin
            s1_sel <= region;
            s1_kbd <= kbd_q;
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Read stage 2: select data, register output and error pulse
   // ---------------------------------------------------------------------------------------
   logic [DATA_W-1:0] rd_data;
   logic              s1_bad;
   logic [DATA_W-1:0] out_q;
   logic              out_valid_q;
   logic              err_q;

   always_comb begin
      rd_data = '0;
      case (s1_sel)
         SEL_RAM: rd_data = ram_q;
         SEL_SCR: rd_data = scr_rdata;
         SEL_KBD: rd_data = s1_kbd;
         default: rd_data = '0;
      endcase
   end

   assign s1_bad = s1_valid && (s1_sel == SEL_BAD);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= s1_valid;
         if (s1_valid) begin
            out_q <= rd_data;
         end
         // Write errors surface one cycle after the write, read errors with their data.
         err_q <= wr_err | s1_bad;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

endmodule

// File: tb/tb_hack_memory_map.sv
// Directed bench for hack_memory_map: one non-sticky and one sticky-keyboard instance share
// stimulus, each with its own synchronous screen RAM model.
module tb_hack_memory_map;

   logic        clk;
   logic        reset;
   logic [15:0] d_in;
   logic        load;
   logic        rd_en;
   logic [14:0] address;
   logic [15:0] kb;
   logic        kb_strobe;

   logic [15:0] out_a, out_b;
   logic        vld_a, vld_b;
   logic        err_a, err_b;
   logic [12:0] scr_addr_a, scr_addr_b;
   logic        scr_we_a, scr_we_b;
   logic [15:0] scr_wdata_a, scr_wdata_b;
   logic [15:0] scr_rdata_a, scr_rdata_b;

   logic [15:0] scr_mem_a [8192];
   logic [15:0] scr_mem_b [8192];

   int n_chk;
   int n_fail;

   hack_memory_map #(.KBD_STICKY(0)) dut (
      .clk(clk), .reset(reset), .in(d_in), .load(load), .rd_en(rd_en), .address(address),
      .out(out_a), .out_valid(vld_a), .err(err_a), .kb(kb), .kb_strobe(kb_strobe),
      .scr_addr(scr_addr_a), .scr_we(scr_we_a), .scr_wdata(scr_wdata_a),
      .scr_rdata(scr_rdata_a)
   );

   hack_memory_map #(.KBD_STICKY(1)) dut_s (
      .clk(clk), .reset(reset), .in(d_in), .load(load), .rd_en(rd_en), .address(address),
      .out(out_b), .out_valid(vld_b), .err(err_b), .kb(kb), .kb_strobe(kb_strobe),
      .scr_addr(scr_addr_b), .scr_we(scr_we_b), .scr_wdata(scr_wdata_b),
      .scr_rdata(scr_rdata_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External framebuffer: synchronous RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (scr_we_a) scr_mem_a[scr_addr_a] <= scr_wdata_a;
      scr_rdata_a <= scr_mem_a[scr_addr_a];
      if (scr_we_b) scr_mem_b[scr_addr_b] <= scr_wdata_b;
      scr_rdata_b <= scr_mem_b[scr_addr_b];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      load      = 1'b0;
      rd_en     = 1'b0;
      kb_strobe = 1'b0;
   endtask

   task automatic wr(input logic [14:0] a, input logic [15:0] d);
      load    = 1'b1;
      rd_en   = 1'b0;
      address = a;
      d_in    = d;
   endtask

   task automatic rd(input logic [14:0] a);
      load    = 1'b0;
      rd_en   = 1'b1;
      address = a;
   endtask

   // Checks out_valid/out/err on both instances.
   task automatic chk_both(input string tag, input logic v, input logic [15:0] d,
                           input logic e);
      chk({tag, "_vld_a"}, {31'd0, vld_a}, {31'd0, v});
      chk({tag, "_vld_b"}, {31'd0, vld_b}, {31'd0, v});
      chk({tag, "_err_a"}, {31'd0, err_a}, {31'd0, e});
      chk({tag, "_err_b"}, {31'd0, err_b}, {31'd0, e});
      if (v) begin
         chk({tag, "_out_a"}, {16'd0, out_a}, {16'd0, d});
         chk({tag, "_out_b"}, {16'd0, out_b}, {16'd0, d});
      end
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      reset     = 1'b0;
      d_in      = 16'h0000;
      address   = 15'h0000;
      kb        = 16'h00A5;
      idle();
      tick();
      tick();
      chk("rst_out_a", {16'd0, out_a}, 32'd0);
      chk("rst_out_b", {16'd0, out_b}, 32'd0);
      chk_both("rst", 1'b0, 16'h0000, 1'b0);
      reset = 1'b1;
      tick();
      chk_both("post_rst", 1'b0, 16'h0000, 1'b0);

      // 1. Reset lands while a read is in stage 1.
      rd(15'h0010);
      tick();
      idle();
      reset = 1'b0;
      tick();
      chk_both("t1_c1", 1'b0, 16'h0000, 1'b0);
      chk("t1_out_a", {16'd0, out_a}, 32'd0);
      reset = 1'b1;
      tick();
      chk_both("t1_c2", 1'b0, 16'h0000, 1'b0);
      tick();

      // 2. RAM write at the top of RAM, then read back.
      wr(15'h3FFF, 16'hBEEF);
      tick();
      rd(15'h3FFF);
      tick();
      idle();
      chk_both("t2_t1", 1'b0, 16'h0000, 1'b0);
      tick();
      chk_both("t2_t2", 1'b1, 16'hBEEF, 1'b0);
      tick();
      chk_both("t2_t3", 1'b0, 16'h0000, 1'b0);
      chk("t2_hold", {16'd0, out_a}, 32'h0000BEEF);

      // 3. Screen write then read through the external model.
      wr(15'h4005, 16'h1234);
      #1;
      chk("t3_we", {31'd0, scr_we_a}, 32'd1);
      chk("t3_addr", {19'd0, scr_addr_a}, 32'h5);
      chk("t3_wdata", {16'd0, scr_wdata_a}, 32'h1234);
      tick();
      rd(15'h4005);
      #1;
      chk("t3_we_rd", {31'd0, scr_we_a}, 32'd0);
      tick();
      idle();
      tick();
      chk_both("t3_rd", 1'b1, 16'h1234, 1'b0);
      tick();

      // 4. Back-to-back reads: RAM, RAM, keyboard.
      wr(15'h0001, 16'h1111);
      tick();
      wr(15'h0002, 16'h2222);
      tick();
      rd(15'h0001);
      tick();
      rd(15'h0002);
      tick();
      chk_both("t4_r1", 1'b1, 16'h1111, 1'b0);
      rd(15'h6000);
      tick();
      chk_both("t4_r2", 1'b1, 16'h2222, 1'b0);
      idle();
      tick();
      chk("t4_r3_vld_a", {31'd0, vld_a}, 32'd1);
      chk("t4_r3_out_a", {16'd0, out_a}, 32'h00A5);
      chk("t4_r3_vld_b", {31'd0, vld_b}, 32'd1);
      chk("t4_r3_out_b", {16'd0, out_b}, 32'h0000);
      tick();
      chk_both("t4_end", 1'b0, 16'h0000, 1'b0);

      // 5. Out-of-map and keyboard writes are dropped and flag err one cycle later.
      wr(15'h2001, 16'h5A5A);
      tick();
      wr(15'h6001, 16'hDEAD);
      #1;
      chk("t5_we_bad", {31'd0, scr_we_a}, 32'd0);
      tick();
      idle();
      chk_both("t5_werr", 1'b0, 16'h0000, 1'b1);
      wr(15'h6000, 16'hCAFE);
      tick();
      idle();
      chk_both("t5_kerr", 1'b0, 16'h0000, 1'b1);
      tick();
      chk_both("t5_kerr_end", 1'b0, 16'h0000, 1'b0);
      rd(15'h2001);
      tick();
      idle();
      tick();
      chk_both("t5_noalias", 1'b1, 16'h5A5A, 1'b0);
      rd(15'h7FFF);
      tick();
      idle();
      chk_both("t5_bad_t1", 1'b0, 16'h0000, 1'b0);
      tick();
      chk_both("t5_bad_t2", 1'b1, 16'h0000, 1'b1);
      tick();
      chk_both("t5_bad_t3", 1'b0, 16'h0000, 1'b0);

      // Simultaneous load and rd_en: write wins, no read result.
      wr(15'h0003, 16'h3333);
      rd_en = 1'b1;
      tick();
      idle();
      tick();
      chk_both("lr_t1", 1'b0, 16'h0000, 1'b0);
      rd(15'h0003);
      tick();
      chk_both("lr_t2", 1'b0, 16'h0000, 1'b0);
      idle();
      tick();
      chk_both("lr_rd", 1'b1, 16'h3333, 1'b0);

      // 6. Sticky keyboard: clear-on-read, then strobe coinciding with the clear.
      kb        = 16'h0041;
      kb_strobe = 1'b1;
      tick();
      kb_strobe = 1'b0;
      rd(15'h6000);
      tick();
      tick();
      chk("t6_r1_out_b", {16'd0, out_b}, 32'h0041);
      chk("t6_r1_out_a", {16'd0, out_a}, 32'h0041);
      idle();
      tick();
      chk("t6_r2_vld_b", {31'd0, vld_b}, 32'd1);
      chk("t6_r2_out_b", {16'd0, out_b}, 32'h0000);
      chk("t6_r2_out_a", {16'd0, out_a}, 32'h0041);
      tick();
      kb        = 16'h0042;
      kb_strobe = 1'b1;
      tick();
      rd(15'h6000);
      kb        = 16'h0055;
      kb_strobe = 1'b1;
      tick();
      kb_strobe = 1'b0;
      tick();
      chk("t6_r3_out_b", {16'd0, out_b}, 32'h0042);
      idle();
      tick();
      chk("t6_r4_vld_b", {31'd0, vld_b}, 32'd1);
      chk("t6_r4_out_b", {16'd0, out_b}, 32'h0055);
      rd(15'h6000);
      tick();
      idle();
      tick();
      chk("t6_r5_out_b", {16'd0, out_b}, 32'h0000);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
